half_adder: RTL and testbench



---
 rtl/half_adder.sv | 55 +++++
 tb/tb_half_adder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Row of WIDTH independent half-adder cells: sum = a ^ b, carry = a & b.
// Outputs are either registered (1-cycle latency) or gated combinationally.
module half_adder #(
   parameter int unsigned WIDTH      = 1,
   parameter bit          REGISTERED = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum,
   output logic [WIDTH-1:0] o_carry,
   output logic             o_valid
);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;

   assign w_sum   = i_a ^ i_b;
   assign w_carry = i_a & i_b;

   if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_carry;
      logic             r_valid;

      // Data loads every cycle; consumers qualify it with o_valid.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_valid <= 1'b0;
         end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
            r_valid <= i_valid;
         end
      end

      assign o_sum   = r_sum;
      assign o_carry = r_carry;
      assign o_valid = r_valid;
   end else begin : g_comb
      logic w_unused_clk;

      assign w_unused_clk = i_clk;

      // Reset acts as an output gate here, not a state element.
      assign o_sum   = i_rst_n ? w_sum   : '0;
      assign o_carry = i_rst_n ? w_carry : '0;
      assign o_valid = i_rst_n & i_valid;
   end

endmodule

// File: tb/tb_half_adder.sv
// Directed checks of half_adder in registered and combinational forms.
// Covers truth table, latency, valid pipelining, async reset, wide rows.
module tb_half_adder;

   logic clk;
   logic rst_n;

   logic a1, b1, v1, s1, c1, ov1;
   logic a0, b0, v0, s0, c0, ov0;
   logic [7:0]  a8, b8, s8, c8;
   logic        v8, ov8;
   logic [15:0] a16, b16, s16, c16;
   logic        v16, ov16;

   int n_cmp;
   int n_err;

   half_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1),
      .i_a(a1), .i_b(b1),
      .o_sum(s1), .o_carry(c1), .o_valid(ov1)
   );

   half_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0),
      .i_a(a0), .i_b(b0),
      .o_sum(s0), .o_carry(c0), .o_valid(ov0)
   );

   half_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_r8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8),
      .i_a(a8), .i_b(b8),
      .o_sum(s8), .o_carry(c8), .o_valid(ov8)
   );

   half_adder #(.WIDTH(16), .REGISTERED(1'b1)) u_r16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16),
      .i_a(a16), .i_b(b16),
      .o_sum(s16), .o_carry(c16), .o_valid(ov16)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag,
                           input logic [32:0] got,
                           input logic [32:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {a,b} stimulus and {carry,sum} results, worked out by hand.
   logic [1:0] va [4];
   logic [1:0] ex [4];
   logic       vv [3];
   logic [32:0] exp16;

   initial begin
      va = '{2'b00, 2'b01, 2'b10, 2'b11};
      ex = '{2'b00, 2'b01, 2'b01, 2'b10};
      vv = '{1'b1, 1'b0, 1'b1};
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
      a0 = 1'b1; b0 = 1'b1; v0 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
      a16 = '0; b16 = '0; v16 = 1'b0;

      #12;
      check_eq("rst_r1", {30'd0, ov1, c1, s1}, 33'd0);
      check_eq("rst_c1", {30'd0, ov0, c0, s0}, 33'd0);
      check_eq("rst_r8", {16'd0, ov8, c8, s8}, 33'd0);
      check_eq("rst_r16", {ov16, c16, s16}, 33'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i < 4) {a1, b1} = va[i];
         v1 = 1'b1;
         #1;
         if (i > 0)
            check_eq($sformatf("r1_tt%0d", i - 1),
                     {30'd0, ov1, c1, s1}, {30'd0, 1'b1, ex[i - 1]});
      end

      for (int i = 0; i < 4; i++) begin
         {a0, b0} = va[i];
         v0 = i[0];
         #1;
         check_eq($sformatf("c1_tt%0d", i),
                  {30'd0, ov0, c0, s0}, {30'd0, i[0], ex[i]});
         #19;
      end

      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i < 3) begin
            {a1, b1} = va[i + 1];
            v1 = vv[i];
         end
         #1;
         if (i > 0)
            check_eq($sformatf("r1_vld%0d", i - 1),
                     {30'd0, ov1, c1, s1}, {30'd0, vv[i - 1], ex[i]});
      end

      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
      a0 = 1'b1; b0 = 1'b1; v0 = 1'b1;
      @(negedge clk);
      #1;
      check_eq("pre_rst", {30'd0, ov1, c1, s1}, 33'h6);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_r1", {30'd0, ov1, c1, s1}, 33'd0);
      check_eq("mid_rst_c1", {30'd0, ov0, c0, s0}, 33'd0);
      check_eq("mid_rst_r8", {16'd0, ov8, c8, s8}, 33'd0);
      a1 = 1'b1; b1 = 1'b0;
      #3;
      rst_n = 1'b1;
      #1;
      check_eq("rel_r1", {30'd0, ov1, c1, s1}, 33'd0);
      check_eq("rel_c1", {30'd0, ov0, c0, s0}, 33'h6);
      @(negedge clk);
      check_eq("post_rst", {30'd0, ov1, c1, s1}, 33'h5);

      @(negedge clk);
      a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF;
      #1;
      check_eq("r8_f0cc", {16'd0, ov8, c8, s8}, {16'd0, 1'b1, 8'hC0, 8'h3C});
      @(negedge clk);
      #1;
      check_eq("r8_ffff", {16'd0, ov8, c8, s8}, {16'd0, 1'b1, 8'hFF, 8'h00});

      exp16 = '0;
      for (int i = 0; i <= 1000; i++) begin
         @(negedge clk);
         if (i > 0)
            check_eq($sformatf("r16_%0d", i - 1), {ov16, c16, s16}, exp16);
         if (i < 1000) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            v16 = 1'($urandom);
            exp16[32] = v16;
            for (int k = 0; k < 16; k++) begin
               int t;
               t = int'(a16[k]) + int'(b16[k]);
               exp16[k]      = (t % 2) == 1;
               exp16[16 + k] = (t / 2) == 1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
